// File: rtl/image_stream_pkg.sv
// Shared types, header constants and pixel conversion for the image stream formatter.
package image_stream_pkg;

   typedef enum logic [1:0] {I_IDLE, I_META, I_PIX} in_state_e;
   typedef enum logic [1:0] {O_IDLE, O_HDR, O_PIX} out_state_e;

   localparam int HDR_WORDS = 4;
   localparam int HDR_BYTES = 6;

   // Round to nearest 8-bit code; only 4088..4095 carry into bit 12 and saturate.
   function automatic logic [7:0] px12_to_8(input logic [11:0] p);
      logic [12:0] s;
      s = {1'b0, p} + 13'd8;
      return s[12] ? 8'hFF : s[11:4];
   endfunction

   function automatic logic [7:0] hdr_byte(input logic [47:0] h, input logic [2:0] idx);
      return h[8*(HDR_BYTES-1-int'(idx)) +: 8];
   endfunction

endpackage

// File: rtl/image_stream_formatter_sync_fifo.sv
// Single-clock FIFO with fall-through read data; full/empty from extra-MSB pointers.
module sync_fifo #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] wdata_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push_i) wptr_q <= wptr_q + (AW+1)'(1);
         if (pop_i)  rptr_q <= rptr_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
   end

   assign rdata_o = mem_q[rptr_q[AW-1:0]];
   assign empty_o = (wptr_q == rptr_q);
   assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/image_stream_formatter.sv
// Converts the camera's 12-bit pixel/metadata stream into header + 8-bit pixel bytes
// for the JPEG block, with a FIFO absorbing output stalls and sticky error flags.
module image_stream_formatter
   import image_stream_pkg::*;
#(
   parameter int FIFO_DEPTH   = 16,
   parameter int FRAME_PIXELS = 5038848
) (
   input  logic        sysClk,
   input  logic        hard_reset,
   input  logic [11:0] image_pixel_data,
   input  logic        image_data_valid,
   input  logic        image_metadata_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_last,
   input  logic        clear_flags,
   output logic        overflow_flag,
   output logic        framing_error_flag,
   output logic        busy
);

   localparam int          CW   = $clog2(FRAME_PIXELS);
   localparam logic [CW-1:0] LAST = CW'(FRAME_PIXELS - 1);

   in_state_e   i_state_q;
   out_state_e  o_state_q;
   logic [1:0]  word_cnt_q;
   logic [47:0] hdr_q, obuf_q;
   logic        hdr_ready_q;
   logic [CW-1:0] in_cnt_q, out_cnt_q;
   logic [2:0]  byte_idx_q;
   logic [7:0]  out_data_q;
   logic        out_valid_q, out_sof_q, out_last_q;
   logic        ovf_q, ferr_q;

   logic        meta_in, pix_in;
   logic        in_err, ovf_evt, hdr_set, hdr_clr, load_ok;
   logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [11:0] fifo_rdata;

   assign meta_in = image_metadata_valid;
   assign pix_in  = image_data_valid && !image_metadata_valid;
   assign load_ok = !out_valid_q || out_ready;
   assign hdr_clr = (o_state_q == O_IDLE) && hdr_ready_q && load_ok;
   assign fifo_pop = (o_state_q == O_PIX) && load_ok && !fifo_empty;

   always_comb begin
      in_err    = 1'b0;
      ovf_evt   = 1'b0;
      hdr_set   = 1'b0;
      fifo_push = 1'b0;
      case (i_state_q)
         I_IDLE: in_err = pix_in || (meta_in && hdr_ready_q);
         I_META: begin
            in_err  = pix_in;
            hdr_set = meta_in && (word_cnt_q == 2'(HDR_WORDS-1));
         end
         I_PIX: begin
            in_err = meta_in;
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            if (pix_in) begin
               if (fifo_full && !fifo_pop) ovf_evt   = 1'b1;
               else                        fifo_push = 1'b1;
            end
         end
         default: ;
      endcase
   end

   sync_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (sysClk),
      .rst_i   (hard_reset),
      .push_i  (fifo_push),
      .pop_i   (fifo_pop),
      .wdata_i (image_pixel_data),
      .rdata_o (fifo_rdata),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_ff @(posedge sysClk or posedge hard_reset) begin
      if (hard_reset) begin
         i_state_q  <= I_IDLE;
         word_cnt_q <= '0;
         hdr_q      <= '0;
         in_cnt_q   <= '0;
      end else begin
         case (i_state_q)
            I_IDLE: if (meta_in && !hdr_ready_q) begin
               hdr_q      <= {hdr_q[35:0], image_pixel_data};
               word_cnt_q <= 2'd1;
               i_state_q  <= I_META;
            end
            I_META: if (meta_in) begin
               hdr_q <= {hdr_q[35:0], image_pixel_data};
               if (hdr_set) begin
                  word_cnt_q <= '0;
                  in_cnt_q   <= '0;
                  i_state_q  <= I_PIX;
               end else begin
                  word_cnt_q <= word_cnt_q + 2'd1;
               end
            end
            I_PIX: if (pix_in) begin
               // Dropped pixels still count so frame boundaries stay aligned.
               if (in_cnt_q == LAST) begin
                  in_cnt_q  <= '0;
                  i_state_q <= I_IDLE;
               end else begin
                  in_cnt_q <= in_cnt_q + CW'(1);
               end
            end
            default: i_state_q <= I_IDLE;
         endcase
      end
   end

   always_ff @(posedge sysClk or posedge hard_reset) begin
      if (hard_reset)   hdr_ready_q <= 1'b0;
      else if (hdr_set) hdr_ready_q <= 1'b1;
      else if (hdr_clr) hdr_ready_q <= 1'b0;
   end

   always_ff @(posedge sysClk or posedge hard_reset) begin
      if (hard_reset) begin
         o_state_q   <= O_IDLE;
         obuf_q      <= '0;
         byte_idx_q  <= '0;
         out_cnt_q   <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sof_q   <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         case (o_state_q)
            O_IDLE: begin
               // Snapshot the header so the next frame's metadata can refill hdr_q.
               if (hdr_clr) begin
                  obuf_q      <= hdr_q;
                  out_data_q  <= hdr_q[47:40];
                  out_valid_q <= 1'b1;
                  out_sof_q   <= 1'b1;
                  out_last_q  <= 1'b0;
                  byte_idx_q  <= 3'd1;
                  o_state_q   <= O_HDR;
               end else if (load_ok) begin
                  out_valid_q <= 1'b0;
                  out_sof_q   <= 1'b0;
                  out_last_q  <= 1'b0;
               end
            end
            O_HDR: if (load_ok) begin
               out_data_q  <= hdr_byte(obuf_q, byte_idx_q);
               out_valid_q <= 1'b1;
               out_sof_q   <= 1'b0;
               out_last_q  <= 1'b0;
               if (byte_idx_q == 3'(HDR_BYTES-1)) begin
                  out_cnt_q <= '0;
                  o_state_q <= O_PIX;
               end else begin
                  byte_idx_q <= byte_idx_q + 3'd1;
               end
            end
            O_PIX: begin
               if (fifo_pop) begin
                  out_data_q  <= px12_to_8(fifo_rdata);
                  out_valid_q <= 1'b1;
                  out_sof_q   <= 1'b0;
                  out_last_q  <= (out_cnt_q == LAST);
                  if (out_cnt_q == LAST) begin
                     out_cnt_q <= '0;
                     o_state_q <= O_IDLE;
                  end else begin
                     out_cnt_q <= out_cnt_q + CW'(1);
                  end
               end else if (load_ok) begin
                  out_valid_q <= 1'b0;
                  out_sof_q   <= 1'b0;
                  out_last_q  <= 1'b0;
               end
            end
            default: o_state_q <= O_IDLE;
         endcase
      end
   end

   // Set events take priority over a simultaneous clear.
   always_ff @(posedge sysClk or posedge hard_reset) begin
      if (hard_reset) begin
         ovf_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         if (ovf_evt)          ovf_q <= 1'b1;
         else if (clear_flags) ovf_q <= 1'b0;
         if (in_err)           ferr_q <= 1'b1;
         else if (clear_flags) ferr_q <= 1'b0;
      end
   end

   assign out_data           = out_data_q;
   assign out_valid          = out_valid_q;
   assign out_sof            = out_sof_q;
   assign out_last           = out_last_q;
   assign overflow_flag      = ovf_q;
   assign framing_error_flag = ferr_q;
   assign busy               = (i_state_q != I_IDLE) || (o_state_q != O_IDLE) || !fifo_empty;

endmodule
